alu_share_arbiter: RTL

Shares a single 8-bit ALU datapath among NUM_REQ requesters.
- Grants one request at a time using round-robin arbitration.
- Latches the operands, executes one ALU operation and returns a registered result tagged with the requester ID.
- Sits between the client blocks and the ALU, so the clients never drive the ALU directly.

---
 rtl/alu_share_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin front end that lets NUM_REQ clients share
// one 8-bit ALU. A request is granted in IDLE and its operands are latched.
// The ALU runs in EXEC, and the registered, ID-tagged result is held in RESP
// until the consumer takes it.
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both high. A requester keeps valid and its
// operands stable until it sees ready. req_ready_o is one-hot or zero and is
// only ever high in IDLE. rsp_valid_o is high only in RESP, and the response
// fields stay constant while rsp_ready_i is low.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic [8*NUM_REQ-1:0] req_a_i,
  input  logic [8*NUM_REQ-1:0] req_b_i,
  input  logic [3*NUM_REQ-1:0] req_op_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [7:0]           rsp_data_o,
  output logic                 rsp_carry_o,
  output logic [ID_W-1:0]      rsp_id_o,
  output logic                 busy_o,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] id_q;
  logic [7:0]      a_q, b_q;
  logic [2:0]      op_q;
  logic [7:0]      rsp_data_q;
  logic            rsp_carry_q;
  logic [ID_W-1:0] rsp_id_q;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_id;
  logic [7:0]      alu_res;
  logic            alu_carry;

  // Unpack the per-requester operand buses so they can be indexed by grant ID.
  logic [7:0] a_arr  [NUM_REQ];
  logic [7:0] b_arr  [NUM_REQ];
  logic [2:0] op_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g]  = req_a_i[8*g +: 8];
    assign b_arr[g]  = req_b_i[8*g +: 8];
    assign op_arr[g] = req_op_i[3*g +: 3];
  end

  // Round-robin search: first valid requester at or above the pointer, wrapping.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      idx = sum[ID_W-1:0];
      if (!gnt_found && req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = idx;
      end
    end
  end

  // ALU evaluated on the latched operands; carry only for ADD/SUB.
  always_comb begin
    logic [8:0] sum9;
    sum9      = {1'b0, a_q} + {1'b0, b_q};
    alu_res   = 8'd0;
    alu_carry = 1'b0;
    case (op_q)
      3'd0: begin alu_res = sum9[7:0]; alu_carry = sum9[8]; end
      3'd1: begin alu_res = a_q - b_q; alu_carry = (a_q < b_q); end
      3'd2: alu_res = a_q << b_q[2:0];
      3'd3: alu_res = a_q >> b_q[2:0];
      3'd4: alu_res = a_q & b_q;
      3'd5: alu_res = a_q | b_q;
      3'd6: alu_res = a_q ^ b_q;
      default: alu_res = {7'd0, (a_q == b_q)};
    endcase
  end

  // Next-state logic: one grant per IDLE cycle, fixed one-cycle EXEC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, operand latch, response registers and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      a_q         <= 8'd0;
      b_q         <= 8'd0;
      op_q        <= 3'd0;
      rsp_data_q  <= 8'd0;
      rsp_carry_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (gnt_found) begin
            id_q <= gnt_id;
            a_q  <= a_arr[gnt_id];
            b_q  <= b_arr[gnt_id];
            op_q <= op_arr[gnt_id];
          end
        end
        EXEC: begin
          rsp_data_q  <= alu_res;
          rsp_carry_q <= alu_carry;
          rsp_id_q    <= id_q;
        end
        RESP: begin
          if (rsp_ready_i) begin
            if (id_q == ID_W'(NUM_REQ - 1)) ptr_q <= '0;
            else                            ptr_q <= id_q + ID_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE && gnt_found) ? (NUM_REQ'(1) << gnt_id) : '0;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_carry_o = rsp_carry_q;
  assign rsp_id_o    = rsp_id_q;
  assign busy_o      = (state_q != IDLE);
  assign state_dbg   = state_q;

endmodule
